// File: rtl/calc_cmd_sequencer.sv
// Command sequencer for the 8-bit accumulator calculator: FIFO, issue FSM, result stream.
// Optional shadow accumulator check enabled by defining CALC_SEQ_SHADOW_CHECK_EN.
module calc_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [2:0] calc_codigo,
    output logic [7:0] calc_entrada,
    input  logic [7:0] calc_saida,
    output logic       res_valid,
    output logic [7:0] res_data,
    input  logic       res_ready,
    output logic       busy,
    output logic       err,
    output logic       mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, push, pop, try_pop;
    logic [2:0]    head_op;
    logic [7:0]    head_data;

    state_t     state, state_n;
    logic [2:0] codigo_n;
    logic [7:0] entrada_n;
    logic [1:0] cur_op, cur_op_n;
    logic       res_valid_n, err_n;
    logic [7:0] res_data_n;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head_op   = mem[rd_ptr][10:8];
    assign head_data = mem[rd_ptr][7:0];
    assign busy      = !empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_op, cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Add/sub may chain straight into the next pop; display ops wait for saida.
    always_comb begin
        state_n     = state;
        codigo_n    = 3'b111;
        entrada_n   = '0;
        cur_op_n    = cur_op;
        res_valid_n = res_valid;
        res_data_n  = res_data;
        err_n       = err;
        try_pop     = 1'b0;
        pop         = 1'b0;
        case (state)
            S_IDLE: try_pop = !empty;
            S_ISSUE: begin
                if (cur_op[1] ^ cur_op[0]) begin
                    try_pop = !empty;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                res_data_n  = calc_saida;
                res_valid_n = 1'b1;
                state_n     = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (try_pop) begin
            pop = 1'b1;
            if (head_op[2]) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end else begin
                codigo_n  = head_op;
                entrada_n = head_data;
                cur_op_n  = head_op[1:0];
                state_n   = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            calc_codigo  <= 3'b111;
            calc_entrada <= '0;
            cur_op       <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            calc_codigo  <= codigo_n;
            calc_entrada <= entrada_n;
            cur_op       <= cur_op_n;
            res_valid    <= res_valid_n;
            res_data     <= res_data_n;
            err          <= err_n;
        end
    end

`ifdef CALC_SEQ_SHADOW_CHECK_EN
    logic [7:0] shadow, shadow_n;
    logic [7:0] cur_data, cur_data_n;
    logic [7:0] expect_val;
    logic       mism_r, mism_n;

    assign expect_val = (cur_op == 2'b11) ? shadow : cur_data;

    always_comb begin
        shadow_n   = shadow;
        cur_data_n = cur_data;
        mism_n     = mism_r;
        if (try_pop && !head_op[2]) begin
            cur_data_n = head_data;
            if (head_op == 3'b001)
                shadow_n = shadow + head_data;
            else if (head_op == 3'b010)
                shadow_n = shadow - head_data;
        end
        if (state == S_WAIT && calc_saida != expect_val)
            mism_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            cur_data <= '0;
            mism_r   <= 1'b0;
        end else begin
            shadow   <= shadow_n;
            cur_data <= cur_data_n;
            mism_r   <= mism_n;
        end
    end

    assign mismatch = mism_r;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with a behavioural calculator attached.
module tb_calc_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [2:0] calc_codigo;
    logic [7:0] calc_entrada, calc_saida;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       busy, err, mismatch;

    logic       force_ff = 1'b0;
    logic [7:0] acc_m, saida_m;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         push_cyc;

    always #5 clk = ~clk;

    calc_cmd_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .calc_codigo(calc_codigo), .calc_entrada(calc_entrada),
        .calc_saida(calc_saida),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err(err), .mismatch(mismatch)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_m   <= '0;
            saida_m <= '0;
        end else begin
            case (calc_codigo)
                3'b000:  saida_m <= calc_entrada;
                3'b001:  acc_m <= acc_m + calc_entrada;
                3'b010:  acc_m <= acc_m - calc_entrada;
                3'b011:  saida_m <= acc_m;
                default: ;
            endcase
        end
    end
    assign calc_saida = force_ff ? 8'hFF : saida_m;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [2:0] op; int c; } ev_t;
    typedef struct { logic [7:0] d; int c; } rs_t;
    ev_t ops_q[$];
    rs_t res_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (calc_codigo != 3'b111) ops_q.push_back('{calc_codigo, cyc});
            if (res_valid && res_ready) res_q.push_back('{res_data, cyc});
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       has_res;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] res_at(input int k);
        return (k < res_q.size()) ? {24'h0, res_q[k].d} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] op_at(input int k);
        return (k < ops_q.size()) ? {29'h0, ops_q[k].op} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] opc_at(input int k);
        return (k < ops_q.size()) ? ops_q[k].c : -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ops_q.delete();
        res_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] data);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check("push_timeout", {31'h0, cmd_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        push_cyc  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy || res_valid) && g < 500);
        if (g >= 500) check("idle_timeout", {31'h0, busy}, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p0, k;
        tbl[0]  = '{3'b001, 8'd5,   1'b0, 8'd0};
        tbl[1]  = '{3'b001, 8'd10,  1'b0, 8'd0};
        tbl[2]  = '{3'b010, 8'd3,   1'b0, 8'd0};
        tbl[3]  = '{3'b011, 8'd0,   1'b1, 8'd12};
        tbl[4]  = '{3'b000, 8'hA5,  1'b1, 8'hA5};
        tbl[5]  = '{3'b010, 8'd12,  1'b0, 8'd0};
        tbl[6]  = '{3'b001, 8'd200, 1'b0, 8'd0};
        tbl[7]  = '{3'b001, 8'd100, 1'b0, 8'd0};
        tbl[8]  = '{3'b011, 8'd0,   1'b1, 8'd44};
        tbl[9]  = '{3'b010, 8'd50,  1'b0, 8'd0};
        tbl[10] = '{3'b011, 8'd0,   1'b1, 8'd250};
        tbl[11] = '{3'b101, 8'd7,   1'b0, 8'd0};
        tbl[12] = '{3'b011, 8'd0,   1'b1, 8'd250};

        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        res_ready = 1'b1;
        do_reset();

        // Reset and idle state
        repeat (5) @(negedge clk);
        check("rst_codigo", {29'h0, calc_codigo}, 3'b111);
        check("rst_entrada", {24'h0, calc_entrada}, 0);
        check("rst_res_valid", {31'h0, res_valid}, 0);
        check("rst_res_data", {24'h0, res_data}, 0);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 1);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_err", {31'h0, err}, 0);
        check("rst_mismatch", {31'h0, mismatch}, 0);

        // Back-to-back issue timing
        push(3'b001, 8'd5);
        p0 = push_cyc;
        push(3'b001, 8'd10);
        push(3'b010, 8'd3);
        push(3'b011, 8'd0);
        wait_idle();
        check("b2b_nops", ops_q.size(), 4);
        check("b2b_op0", op_at(0), 3'b001);
        check("b2b_c0", opc_at(0), p0 + 1);
        check("b2b_op1", op_at(1), 3'b001);
        check("b2b_c1", opc_at(1), p0 + 2);
        check("b2b_op2", op_at(2), 3'b010);
        check("b2b_c2", opc_at(2), p0 + 3);
        check("b2b_op3", op_at(3), 3'b011);
        check("b2b_c3", opc_at(3), p0 + 4);
        check("b2b_nres", res_q.size(), 1);
        check("b2b_res", res_at(0), 12);
        check("b2b_res_c", (res_q.size() > 0) ? res_q[0].c : -1, p0 + 6);

        // Table-driven command stream
        do_reset();
        for (int i = 0; i < 13; i++) push(tbl[i].op, tbl[i].data);
        wait_idle();
        k = 0;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].has_res) begin
                check($sformatf("tbl_res%0d", i), res_at(k), {24'h0, tbl[i].exp});
                k++;
            end
        end
        check("tbl_nres", res_q.size(), k);
        k = 0;
        for (int i = 0; i < 13; i++) begin
            if (!tbl[i].op[2]) begin
                check($sformatf("tbl_op%0d", i), op_at(k), {29'h0, tbl[i].op});
                k++;
            end
        end
        check("tbl_nops", ops_q.size(), k);
        check("tbl_err", {31'h0, err}, 1);
        check("tbl_mismatch", {31'h0, mismatch}, 0);

        // Backpressure: FIFO fills behind a held result
        do_reset();
        res_ready = 1'b0;
        push(3'b011, 8'd0);
        push(3'b001, 8'd1);
        push(3'b001, 8'd2);
        push(3'b001, 8'd3);
        push(3'b011, 8'd0);
        check("bp_full", {31'h0, cmd_ready}, 0);
        repeat (5) @(negedge clk);
        check("bp_nops_held", ops_q.size(), 1);
        check("bp_res_valid", {31'h0, res_valid}, 1);
        check("bp_res_data", {24'h0, res_data}, 0);
        check("bp_busy", {31'h0, busy}, 1);
        res_ready = 1'b1;
        wait_idle();
        check("bp_nres", res_q.size(), 2);
        check("bp_res0", res_at(0), 0);
        check("bp_res1", res_at(1), 6);
        check("bp_nops", ops_q.size(), 5);
        check("bp_op1", op_at(1), 3'b001);
        check("bp_op4", op_at(4), 3'b011);
        check("bp_err", {31'h0, err}, 0);

        // Asynchronous reset mid-operation
        do_reset();
        push(3'b001, 8'd5);
        push(3'b011, 8'd0);
        #2 rst = 1'b1;
        #1;
        check("ar_codigo", {29'h0, calc_codigo}, 3'b111);
        check("ar_entrada", {24'h0, calc_entrada}, 0);
        check("ar_busy", {31'h0, busy}, 0);
        check("ar_cmd_ready", {31'h0, cmd_ready}, 1);
        ops_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("ar_nops", ops_q.size(), 0);
        check("ar_nres", res_q.size(), 0);

`ifdef CALC_SEQ_SHADOW_CHECK_EN
        do_reset();
        force_ff = 1'b1;
        push(3'b011, 8'd0);
        wait_idle();
        force_ff = 1'b0;
        check("sh_res", res_at(0), 8'hFF);
        check("sh_mismatch", {31'h0, mismatch}, 1);
        push(3'b001, 8'd4);
        push(3'b011, 8'd0);
        wait_idle();
        check("sh_res2", res_at(1), 4);
        check("sh_sticky", {31'h0, mismatch}, 1);
        do_reset();
        check("sh_cleared", {31'h0, mismatch}, 0);
`else
        check("nosh_mismatch", {31'h0, mismatch}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
